// File: rtl/block_draw_datapath.sv
// rtl/block_draw_datapath.sv - moving-block position, pixel sweep, frame delay and stop latch
module block_draw_datapath #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int BLK_W   = 16,
  parameter int BLK_H   = 4,
  parameter int X_MAX   = 159,
  parameter int X_START = 0,
  parameter int Y_START = 116,
  parameter int DELAY   = 833333,
  parameter int CNT_W   = 20
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           reset_load,
  input  logic           reset_counter,
  input  logic           enable_counter,
  input  logic           ld_x,
  input  logic           ld_y,
  input  logic           count_x_enable,
  input  logic           colour_erase_enable,
  input  logic [2:0]     colour_in,
  input  logic           stop_req,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [2:0]     colour_out,
  output logic           done_plot,
  output logic           enable_erase,
  output logic           stop_true
);

  localparam int PX_W = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam int PY_W = (BLK_H > 1) ? $clog2(BLK_H) : 1;

  localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(BLK_W - 1);
  localparam logic [PY_W-1:0]  PY_LAST  = PY_W'(BLK_H - 1);
  localparam logic [PX_W-1:0]  PX_ONE   = PX_W'(1);
  localparam logic [PY_W-1:0]  PY_ONE   = PY_W'(1);
  localparam logic [X_W-1:0]   X_ONE    = X_W'(1);
  localparam logic [X_W-1:0]   X_RIGHT  = X_W'(BLK_W - 1);
  localparam logic [X_W-1:0]   X_LIM    = X_W'(X_MAX);
  localparam logic [X_W-1:0]   X_INIT   = X_W'(X_START);
  localparam logic [Y_W-1:0]   Y_INIT   = Y_W'(Y_START);
  localparam logic [Y_W-1:0]   Y_STEP   = Y_W'(BLK_H);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [X_W-1:0]   x_pos;
  logic [Y_W-1:0]   y_pos;
  logic             dir;
  logic [PX_W-1:0]  px;
  logic [PY_W-1:0]  py;
  logic [CNT_W-1:0] cnt;
  logic             sync1, sync2, sync3;
  logic             stop_latch;
  logic             px_last, py_last, stop_rise;

  assign px_last   = (px == PX_LAST);
  assign py_last   = (py == PY_LAST);
  assign stop_rise = sync2 & ~sync3;

  // Combinational so the VGA samples coordinates on the same edge as writeEn.
  assign x_out        = x_pos + X_W'(px);
  assign y_out        = y_pos + Y_W'(py);
  assign colour_out   = colour_erase_enable ? 3'b000 : colour_in;
  assign done_plot    = count_x_enable && px_last && py_last;
  assign enable_erase = enable_counter && (cnt == CNT_LAST);
  assign stop_true    = stop_latch;

  always_ff @(posedge clk) begin
    if (!resetn || !reset_load) begin
      x_pos <= X_INIT;
      y_pos <= Y_INIT;
      dir   <= 1'b1;
      px    <= '0;
      py    <= '0;
    end else begin
      if (count_x_enable) begin
        if (px_last) begin
          px <= '0;
          py <= py_last ? '0 : py + PY_ONE;
        end else begin
          px <= px + PX_ONE;
        end
      end
      // A latched stop freezes the column so the block stacks straight down.
      if (ld_x && !stop_latch) begin
        if (dir) begin
          if (x_pos + X_RIGHT < X_LIM) begin
            x_pos <= x_pos + X_ONE;
          end else begin
            dir   <= 1'b0;
            x_pos <= x_pos - X_ONE;
          end
        end else if (x_pos != '0) begin
          x_pos <= x_pos - X_ONE;
        end else begin
          dir   <= 1'b1;
          x_pos <= x_pos + X_ONE;
        end
      end
      if (ld_y && stop_latch) begin
        y_pos <= (y_pos < Y_STEP) ? '0 : y_pos - Y_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || !reset_counter) begin
      cnt <= '0;
    end else if (enable_counter && cnt < CNT_LAST) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Set beats clear so a press landing on the consume cycle is not lost.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      stop_latch <= 1'b0;
    end else begin
      sync1 <= stop_req;
      sync2 <= sync1;
      sync3 <= sync2;
      if (stop_rise) begin
        stop_latch <= 1'b1;
      end else if (ld_y) begin
        stop_latch <= 1'b0;
      end
    end
  end

endmodule
